// File: rtl/pps_source_select.sv
// PPS source selector: priority arbitration between qualified PPS sources, with a
// flywheel that carries phase through source switches and a bounded holdover.
module pps_source_select #(
    parameter int CLK_RATE         = -1,
    parameter int NSRC             = 2,
    parameter int HOLDOVER_SECONDS = 10
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NSRC-1:0]                            srcStrobe,
    input  logic [NSRC-1:0]                            srcValid,
    input  logic [NSRC-1:0]                            srcEnable,
    input  logic                                       revertive,
    output logic                                       ppsOut,
    output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] activeSrc,
    output logic [1:0]                                 state,
    output logic                                       ppsLost
);
    localparam int SRC_W     = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int RATE      = (CLK_RATE >= 16) ? CLK_RATE : 16;
    localparam int TMO_CYC   = RATE + RATE / 10;
    localparam int FLY_W     = $clog2(RATE);
    localparam int TMO_W     = $clog2(TMO_CYC);
    localparam int HOLD_W    = $clog2(HOLDOVER_SECONDS + 1);
    localparam int HOLD_LAST = HOLDOVER_SECONDS - 1;

    typedef enum logic [1:0] {
        ACQUIRE  = 2'd0,
        LOCKED   = 2'd1,
        SWITCH   = 2'd2,
        HOLDOVER = 2'd3
    } selState_t;

    selState_t         stateQ, stateNext;
    logic [SRC_W-1:0]  activeNext, best;
    logic [FLY_W-1:0]  fly, flyNext;
    logic [TMO_W-1:0]  tmo, tmoNext;
    logic [HOLD_W-1:0] holdCount, holdNext;
    logic              aligned, alignedNext, pulse;
    logic [NSRC-1:0]   usable;
    logic              anyUsable, activeStrobe, activeUsable, flyWrap, tmoDone;

    assign usable       = srcValid & srcEnable;
    assign anyUsable    = |usable;
    assign activeStrobe = srcStrobe[activeSrc];
    assign activeUsable = usable[activeSrc];
    assign flyWrap      = (fly == FLY_W'(RATE - 1));
    assign tmoDone      = (tmo == TMO_W'(TMO_CYC - 1));
    assign state        = stateQ;

    // Lowest usable index wins; with a single source this is constantly 0.
    always_comb begin
        best = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (usable[i]) best = SRC_W'(i);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        stateNext   = stateQ;
        activeNext  = activeSrc;
        flyNext     = flyWrap ? '0 : fly + 1'b1;
        tmoNext     = '0;
        holdNext    = holdCount;
        alignedNext = aligned;
        pulse       = 1'b0;
        case (stateQ)
            ACQUIRE: begin
                alignedNext = 1'b0;
                if (anyUsable) begin
                    activeNext = best;
                    stateNext  = SWITCH;
                end
            end
            SWITCH: begin
                tmoNext = tmo + 1'b1;
                pulse   = aligned && flyWrap;
                // Loss beats a coincident strobe; a strobe beats a coincident timeout.
                if (!activeUsable) begin
                    stateNext = aligned ? HOLDOVER : ACQUIRE;
                    holdNext  = '0;
                end else if (activeStrobe) begin
                    flyNext     = '0;
                    alignedNext = 1'b1;
                    pulse       = 1'b1;
                    stateNext   = LOCKED;
                end else if (tmoDone) begin
                    stateNext = aligned ? HOLDOVER : ACQUIRE;
                    holdNext  = '0;
                end
            end
            LOCKED: begin
                if (activeUsable && activeStrobe) begin
                    pulse   = 1'b1;
                    flyNext = '0;
                end
                if (!activeUsable) begin
                    if (anyUsable) begin
                        activeNext = best;
                        stateNext  = SWITCH;
                    end else begin
                        stateNext = HOLDOVER;
                        holdNext  = '0;
                    end
                end else if (revertive && best < activeSrc) begin
                    activeNext = best;
                    stateNext  = SWITCH;
                end
            end
            HOLDOVER: begin
                pulse = flyWrap;
                if (flyWrap) holdNext = holdCount + 1'b1;
                if (anyUsable) begin
                    activeNext = best;
                    stateNext  = SWITCH;
                end else if (flyWrap && holdCount == HOLD_W'(HOLD_LAST)) begin
                    stateNext   = ACQUIRE;
                    alignedNext = 1'b0;
                end
            end
            default: stateNext = ACQUIRE;
        endcase
    end

    always_comb begin
        ppsLost = 1'b0;
        case (stateQ)
            ACQUIRE: ppsLost = 1'b1;
            SWITCH:  ppsLost = ~aligned;
            default: ppsLost = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= ACQUIRE;
            activeSrc <= '0;
            fly       <= '0;
            tmo       <= '0;
            holdCount <= '0;
            aligned   <= 1'b0;
            ppsOut    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            stateQ    <= stateNext;
            activeSrc <= activeNext;
            fly       <= flyNext;
            tmo       <= tmoNext;
            holdCount <= holdNext;
            aligned   <= alignedNext;
            // Guarantees ppsOut is never high on two consecutive cycles.
            ppsOut    <= pulse & ~ppsOut;
        end
    end
endmodule

// File: tb/tb_pps_source_select.sv
// Self-checking bench for pps_source_select: expected ppsOut cycles are queued as
// stimulus is driven and matched against observed pulses by a negedge monitor.
module tb_pps_source_select;
    localparam int CLK_RATE = 1000;
    localparam int NSRC     = 2;
    localparam int HOLD_S   = 3;

    localparam logic [1:0] S_ACQ  = 2'd0;
    localparam logic [1:0] S_LOCK = 2'd1;
    localparam logic [1:0] S_SW   = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSRC-1:0] srcStrobe, srcValid, srcEnable;
    logic            revertive;
    logic            ppsOut;
    logic [0:0]      activeSrc;
    logic [1:0]      state;
    logic            ppsLost;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int lastStrobe = 0;
    int flyRef     = 0;
    int expQ[$];

    pps_source_select #(
        .CLK_RATE(CLK_RATE),
        .NSRC(NSRC),
        .HOLDOVER_SECONDS(HOLD_S)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .srcStrobe(srcStrobe),
        .srcValid(srcValid),
        .srcEnable(srcEnable),
        .revertive(revertive),
        .ppsOut(ppsOut),
        .activeSrc(activeSrc),
        .state(state),
        .ppsLost(ppsLost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            while (expQ.size() > 0 && expQ[0] < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL pps_missed: no pulse at cycle %0d, required one there", expQ[0]);
                void'(expQ.pop_front());
            end
            if (ppsOut) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL pps_unexpected: pulse at cycle %0d, required none", cyc);
                end else if (expQ[0] != cyc) begin
                    mismatched++;
                    $display("FAIL pps_timing: pulse at cycle %0d, required at %0d", cyc, expQ[0]);
                end else begin
                    void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, stuck at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) tick();
    endtask

    task automatic strobe(input int idx, input bit expPulse);
        srcStrobe[idx] = 1'b1;
        if (expPulse) expQ.push_back(cyc + 1);
        tick();
        srcStrobe[idx] = 1'b0;
        if (expPulse) lastStrobe = cyc;
    endtask

    task automatic test_reset();
        // NOTE: bench drives inputs with blocking assignments, #1 after the edge, away from DUT sampling.
        rst_n = 1'b0; srcStrobe = '0; srcValid = '0; srcEnable = 2'b11; revertive = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (state !== S_ACQ) begin mismatched++; $display("FAIL reset_state: got %0d want %0d", state, S_ACQ); end
        compared++; if (ppsOut !== 1'b0) begin mismatched++; $display("FAIL reset_ppsOut: got %b want 0", ppsOut); end
        compared++; if (activeSrc !== 1'b0) begin mismatched++; $display("FAIL reset_activeSrc: got %0d want 0", activeSrc); end
        compared++; if (ppsLost !== 1'b1) begin mismatched++; $display("FAIL reset_ppsLost: got %b want 1", ppsLost); end
        rst_n = 1'b1;
        tick(); tick();
        compared++; if (state !== S_ACQ) begin mismatched++; $display("FAIL idle_no_source: got %0d want %0d", state, S_ACQ); end
    endtask

    task automatic test_lock();
        srcValid = 2'b01;
        tick();
        compared++; if (state !== S_SW || activeSrc !== 1'b0) begin mismatched++; $display("FAIL lock_enter_switch: state %0d src %0d want %0d src 0", state, activeSrc, S_SW); end
        compared++; if (ppsLost !== 1'b1) begin mismatched++; $display("FAIL lock_switch_lost: got %b want 1", ppsLost); end
        strobe(0, 1'b1);
        compared++; if (state !== S_LOCK || ppsLost !== 1'b0) begin mismatched++; $display("FAIL lock_locked: state %0d lost %b want %0d lost 0", state, ppsLost, S_LOCK); end
        for (int k = 0; k < 2; k++) begin
            waitUntil(lastStrobe + CLK_RATE - 1);
            strobe(0, 1'b1);
        end
        compared++; if (state !== S_LOCK || activeSrc !== 1'b0) begin mismatched++; $display("FAIL lock_steady: state %0d src %0d want %0d src 0", state, activeSrc, S_LOCK); end
    endtask

    task automatic test_failover();
        int p;
        p = lastStrobe;
        waitUntil(p + 400);
        srcValid = 2'b10;
        tick();
        compared++; if (state !== S_SW || activeSrc !== 1'b1) begin mismatched++; $display("FAIL failover_switch: state %0d src %0d want %0d src 1", state, activeSrc, S_SW); end
        compared++; if (ppsLost !== 1'b0) begin mismatched++; $display("FAIL failover_lost: got %b want 0", ppsLost); end
        expQ.push_back(p + CLK_RATE);
        waitUntil(p + 700);
        strobe(0, 1'b0);
        waitUntil(p + 1200);
        strobe(1, 1'b1);
        compared++; if (state !== S_LOCK || activeSrc !== 1'b1) begin mismatched++; $display("FAIL failover_locked: state %0d src %0d want %0d src 1", state, activeSrc, S_LOCK); end
    endtask

    task automatic test_holdover();
        int q;
        q = lastStrobe;
        waitUntil(q + 300);
        srcValid = 2'b00;
        tick();
        compared++; if (state !== S_HOLD || ppsLost !== 1'b0) begin mismatched++; $display("FAIL hold_enter: state %0d lost %b want %0d lost 0", state, ppsLost, S_HOLD); end
        for (int k = 1; k <= HOLD_S; k++) expQ.push_back(q + k * CLK_RATE);
        waitUntil(q + HOLD_S * CLK_RATE - 1);
        compared++; if (state !== S_HOLD) begin mismatched++; $display("FAIL hold_before_last: got %0d want %0d", state, S_HOLD); end
        tick();
        compared++; if (state !== S_ACQ || ppsLost !== 1'b1) begin mismatched++; $display("FAIL hold_expired: state %0d lost %b want %0d lost 1", state, ppsLost, S_ACQ); end
        waitUntil(q + 4200);
        compared++; if (state !== S_ACQ) begin mismatched++; $display("FAIL hold_stays_acq: got %0d want %0d", state, S_ACQ); end
    endtask

    task automatic test_revert();
        int r, s;
        srcValid = 2'b10; revertive = 1'b1;
        tick();
        compared++; if (state !== S_SW || activeSrc !== 1'b1) begin mismatched++; $display("FAIL revert_acq_src1: state %0d src %0d want %0d src 1", state, activeSrc, S_SW); end
        strobe(1, 1'b1);
        r = lastStrobe;
        waitUntil(r + 200);
        srcValid = 2'b11;
        tick();
        compared++; if (state !== S_SW || activeSrc !== 1'b0) begin mismatched++; $display("FAIL revert_switch: state %0d src %0d want %0d src 0", state, activeSrc, S_SW); end
        waitUntil(r + 500);
        strobe(0, 1'b1);
        compared++; if (state !== S_LOCK || activeSrc !== 1'b0) begin mismatched++; $display("FAIL revert_locked: state %0d src %0d want %0d src 0", state, activeSrc, S_LOCK); end
        s = lastStrobe;
        waitUntil(s + 100);
        revertive = 1'b0; srcValid = 2'b10;
        tick();
        waitUntil(s + 300);
        strobe(1, 1'b1);
        waitUntil(s + 400);
        srcValid = 2'b11;
        waitUntil(s + 410);
        compared++; if (state !== S_LOCK || activeSrc !== 1'b1) begin mismatched++; $display("FAIL nonrevert_stays: state %0d src %0d want %0d src 1", state, activeSrc, S_LOCK); end
        waitUntil(s + 700);
        strobe(0, 1'b0);
        waitUntil(s + 1300);
        strobe(1, 1'b1);
        compared++; if (state !== S_LOCK || activeSrc !== 1'b1) begin mismatched++; $display("FAIL nonrevert_locked: state %0d src %0d want %0d src 1", state, activeSrc, S_LOCK); end
    endtask

    task automatic test_timeout();
        int t0, n;
        t0 = lastStrobe;
        waitUntil(t0 + 10);
        srcValid = 2'b01;
        tick();
        compared++; if (state !== S_SW || activeSrc !== 1'b0) begin mismatched++; $display("FAIL tmo_switch: state %0d src %0d want %0d src 0", state, activeSrc, S_SW); end
        expQ.push_back(t0 + CLK_RATE);
        n = 0;
        while (state === S_SW && n < 1200) begin tick(); n++; end
        compared++; if (n != 1100) begin mismatched++; $display("FAIL tmo_aligned_cycles: got %0d want 1100", n); end
        compared++; if (state !== S_HOLD) begin mismatched++; $display("FAIL tmo_to_holdover: got %0d want %0d", state, S_HOLD); end
        tick();
        compared++; if (state !== S_SW) begin mismatched++; $display("FAIL tmo_reenter: got %0d want %0d", state, S_SW); end
        // Strobe accepted on the same edge as the flywheel wrap: one pulse only.
        waitUntil(t0 + 2 * CLK_RATE - 1);
        strobe(0, 1'b1);
        compared++; if (state !== S_LOCK || activeSrc !== 1'b0) begin mismatched++; $display("FAIL coincident_locked: state %0d src %0d want %0d src 0", state, activeSrc, S_LOCK); end
    endtask

    task automatic test_back_to_back();
        int u;
        u = lastStrobe;
        waitUntil(u + CLK_RATE - 1);
        srcStrobe[0] = 1'b1;
        expQ.push_back(u + CLK_RATE);
        tick(); tick();
        srcStrobe[0] = 1'b0;
        flyRef = cyc;
        compared++; if (ppsOut !== 1'b0) begin mismatched++; $display("FAIL b2b_second_pulse: got %b want 0", ppsOut); end
    endtask

    task automatic test_async_reset();
        int w, n;
        w = flyRef;
        waitUntil(w + 10);
        srcValid = 2'b00;
        tick();
        compared++; if (state !== S_HOLD) begin mismatched++; $display("FAIL areset_hold: got %0d want %0d", state, S_HOLD); end
        waitUntil(w + CLK_RATE);
        compared++; if (ppsOut !== 1'b1) begin mismatched++; $display("FAIL areset_hold_pulse: got %b want 1", ppsOut); end
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if (ppsOut !== 1'b0 || state !== S_ACQ) begin mismatched++; $display("FAIL areset_immediate: ppsOut %b state %0d want 0 state %0d", ppsOut, state, S_ACQ); end
        compared++; if (ppsLost !== 1'b1 || activeSrc !== 1'b0) begin mismatched++; $display("FAIL areset_lost: lost %b src %0d want 1 src 0", ppsLost, activeSrc); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; srcValid = 2'b01;
        tick();
        compared++; if (state !== S_SW || ppsLost !== 1'b1) begin mismatched++; $display("FAIL areset_switch: state %0d lost %b want %0d lost 1", state, ppsLost, S_SW); end
        n = 0;
        while (state === S_SW && n < 1200) begin tick(); n++; end
        compared++; if (n != 1100 || state !== S_ACQ) begin mismatched++; $display("FAIL tmo_unaligned: %0d cycles state %0d want 1100 state %0d", n, state, S_ACQ); end
        tick();
        strobe(0, 1'b1);
        compared++; if (state !== S_LOCK || ppsLost !== 1'b0) begin mismatched++; $display("FAIL areset_relock: state %0d lost %b want %0d lost 0", state, ppsLost, S_LOCK); end
        waitUntil(lastStrobe + CLK_RATE - 1);
        strobe(0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_failover();
        test_holdover();
        test_revert();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        waitUntil(cyc + 5);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
